// File: rtl/cla_pkg.sv
// Shared definitions for the block-serial CLA adder/subtractor: FSM encoding,
// default geometry and the per-bit generate/propagate helper.
package cla_pkg;

  localparam int unsigned CLA_WIDTH_DEFAULT = 16;
  localparam int unsigned CLA_BLK_DEFAULT   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t bit_gp(input logic a_bit, input logic b_bit);
    gp_t r;
    r.g = a_bit & b_bit;
    r.p = a_bit ^ b_bit;
    return r;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational BLK-bit carry-lookahead slice. c_msb is the carry into the
// slice MSB, needed for signed overflow on the most significant slice.
module cla_slice
  import cla_pkg::*;
#(
  parameter int unsigned BLK = CLA_BLK_DEFAULT
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  always_comb begin
    gp_t gp;
    gp = '0;
    g  = '0;
    p  = '0;
    for (int unsigned i = 0; i < BLK; i++) begin
      gp   = bit_gp(a[i], b[i]);
      g[i] = gp.g;
      p[i] = gp.p;
    end
  end

  // Each carry is the flat sum-of-products over all lower generates plus the
  // fully propagated carry-in, so no carry depends on another carry.
  always_comb begin
    logic term;
    logic ci;
    term = 1'b0;
    ci   = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < BLK; i++) begin
      ci = 1'b0;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        ci = ci | term;
      end
      term = cin;
      for (int unsigned k = 0; k <= i; k++) begin
        term = term & p[k];
      end
      c[i+1] = ci | term;
    end
  end

  assign s     = p ^ c[BLK-1:0];
  assign cout  = c[BLK];
  assign c_msb = c[BLK-1];

endmodule

// File: rtl/cla_addsub_serial.sv
// Block-serial CLA adder/subtractor: one BLK-bit slice per clock, with
// valid/ready handshakes on both sides and signed overflow detection.
module cla_addsub_serial
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH_DEFAULT,
  parameter int unsigned BLK   = CLA_BLK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NBLK = WIDTH / BLK;
  localparam int unsigned CW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBLK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]    lo;
  logic [BLK-1:0] sl_s;
  logic           sl_cout;
  logic           sl_c_msb;

  assign lo = 32'(cnt_q) * 32'(BLK);

  cla_slice #(
    .BLK (BLK)
  ) u_slice (
    .a     (a_q[lo +: BLK]),
    .b     (b_q[lo +: BLK]),
    .cin   (carry_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_c_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~cin, so borrow-in becomes inverted carry-in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ^ cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[lo +: BLK] = sl_s;
        carry_d          = sl_cout;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = sl_cout;
          ovf_d   = sl_c_msb ^ sl_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_addsub_serial.sv
// Directed-vector and randomised bench for cla_addsub_serial (WIDTH=16, BLK=4).
module tb_cla_addsub_serial;

  localparam int W = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_addsub_serial #(
    .WIDTH (16),
    .BLK   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result sign rule.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                       input logic msub, output logic [W-1:0] ms, output logic mc,
                       output logic mo);
    logic [W:0] full;
    if (msub) begin
      full = {1'b0, ma} + {1'b0, ~mb} + {{W{1'b0}}, ~mcin};
      mo   = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
      mo   = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
    end
    ms = full[W-1:0];
    mc = full[W];
  endtask

  // Issues one operation, checks latency and result, stalls, then drains.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                       input logic tsub, input logic [W-1:0] es, input logic ec,
                       input logic eo, input int stall);
    int lat;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb_;
    cin       = tcin;
    sub       = tsub;
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom_range(0, 1));
    sub      = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", 32'(lat), 32'(LAT));
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("ovf", 32'(ovf), 32'(eo));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'(es));
      chk("stall_cout", 32'(cout), 32'(ec));
      chk("stall_ovf", 32'(ovf), 32'(eo));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc, ro;
    logic [W-1:0] ra, rb;
    logic         rcin, rsub;
    int           lat;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[9] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].s, vecs[i].c, vecs[i].o, i % 3);
    end

    // Backpressure plus an in_valid pulse during RUN that must be ignored.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_in_ready_run", 32'(in_ready), 32'd0);
    chk("bp_busy_run", 32'(busy), 32'd1);
    a = 16'h0001; b = 16'h0001; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency_rest", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h8000);
      chk("bp_cout", 32'(cout), 32'd0);
      chk("bp_ovf", 32'(ovf), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_drain_out_valid", 32'(out_valid), 32'd0);
    chk("bp_drain_in_ready", 32'(in_ready), 32'd1);

    // Reset two cycles after acceptance aborts the operation.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      model(ra, rb, rcin, rsub, rs, rc, ro);
      do_op(ra, rb, rcin, rsub, rs, rc, ro, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
